// File: rtl/mul_sequencer_6801_pkg.sv
// Shared types for the 6801 MUL sequencer: accumulator control codes and FSM states.
package mul_sequencer_6801_pkg;

  typedef enum logic [2:0] {
    reset_acca,
    load_acca,
    load_hi_acca,
    pull_acca,
    latch_acca
  } acca_type;

  typedef enum logic [1:0] {
    reset_accb,
    load_accb,
    pull_accb,
    latch_accb
  } accb_type;

  typedef enum logic [1:0] {
    mul_idle,
    mul_calc,
    mul_write
  } mul_state_type;

endpackage

// File: rtl/mul_step_6801.sv
// One shift-add step of the MUL datapath: adds mcand * slice, shifted into place, to P.
module mul_step_6801 #(
  parameter int unsigned STEP_BITS = 1
) (
  input  logic [16:0]          p_i,
  input  logic [7:0]           mcand_i,
  input  logic [STEP_BITS-1:0] slice_i,
  input  logic [2:0]           shift_i,
  output logic [16:0]          p_o
);

  logic [16:0] partial;

  // Partial product for this slice, aligned to its bit position, accumulated into P.
  always_comb begin
    partial = (17'(mcand_i) * 17'(slice_i)) << shift_i;
    p_o     = p_i + partial;
  end

endmodule

// File: rtl/mul_sequencer_6801.sv
// 6801 MUL sequencer: captures ACCA/ACCB, multiplies by iterative shift-add,
// then requests a one-cycle load of the product into ACCA:ACCB.
module mul_sequencer_6801
  import mul_sequencer_6801_pkg::*;
#(
  parameter int unsigned STEP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        start,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        c_out,
  output acca_type    acca_ctrl,
  output accb_type    accb_ctrl
);

  localparam int unsigned CALC_CYCLES = 8 / STEP_BITS;
  localparam logic [2:0]  LAST_CNT    = 3'(CALC_CYCLES - 1);

  mul_state_type state_q, state_d;
  logic [7:0]    mcand_q, mcand_d;
  logic [7:0]    mplier_q, mplier_d;
  logic [16:0]   p_q, p_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   product_q, product_d;

  logic [2:0]           shift;
  logic [STEP_BITS-1:0] slice;
  logic [16:0]          p_next;

  // Select the multiplier slice consumed in the current CALC cycle.
  always_comb begin
    shift = cnt_q * 3'(STEP_BITS);
    slice = mplier_q[shift +: STEP_BITS];
  end

  mul_step_6801 #(
    .STEP_BITS(STEP_BITS)
  ) u_step (
    .p_i     (p_q),
    .mcand_i (mcand_q),
    .slice_i (slice),
    .shift_i (shift),
    .p_o     (p_next)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= mul_idle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state logic and accumulator controls; hold freezes everything and blocks loads.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done      = 1'b0;
    acca_ctrl = latch_acca;
    accb_ctrl = latch_accb;
    if (!hold) begin
      case (state_q)
        mul_idle: begin
          if (start) begin
            mcand_d  = a_in;
            mplier_d = b_in;
            p_d      = '0;
            cnt_d    = '0;
            state_d  = mul_calc;
          end
        end
        mul_calc: begin
          p_d = p_next;
          if (cnt_q == LAST_CNT) begin
            // Product register is loaded on the last CALC edge so it is valid throughout WRITE.
            product_d = p_next[15:0];
            cnt_d     = '0;
            state_d   = mul_write;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        mul_write: begin
          done      = 1'b1;
          acca_ctrl = load_hi_acca;
          accb_ctrl = load_accb;
          state_d   = mul_idle;
        end
        default: state_d = mul_idle;
      endcase
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    busy    = (state_q != mul_idle);
    product = product_q;
    c_out   = product_q[7];
  end

endmodule

// File: tb/tb_mul_sequencer_6801.sv
// Directed bench for mul_sequencer_6801; cycle 1 is the cycle after the start edge.
module tb_mul_sequencer_6801;
  import mul_sequencer_6801_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;

  logic        busy1, done1, c1;
  logic [15:0] prod1;
  acca_type    acca1;
  accb_type    accb1;
  logic        busy2, done2, c2;
  logic [15:0] prod2;
  acca_type    acca2;
  accb_type    accb2;
  logic        busy4, done4, c4;
  logic [15:0] prod4;
  acca_type    acca4;
  accb_type    accb4;

  int total = 0;
  int bad = 0;

  logic [7:0] acc_a = '0;
  logic [7:0] acc_b = '0;
  int         loads = 0;

  always #5 clk = ~clk;

  mul_sequencer_6801 #(.STEP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .product(prod1), .c_out(c1),
    .acca_ctrl(acca1), .accb_ctrl(accb1)
  );
  mul_sequencer_6801 #(.STEP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy2), .done(done2), .product(prod2), .c_out(c2),
    .acca_ctrl(acca2), .accb_ctrl(accb2)
  );
  mul_sequencer_6801 #(.STEP_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy4), .done(done4), .product(prod4), .c_out(c4),
    .acca_ctrl(acca4), .accb_ctrl(accb4)
  );

  // CPU accumulator model driven by dut1's control outputs.
  always @(posedge clk) begin
    if (!hold) begin
      if (acca1 == load_hi_acca) begin
        acc_a <= prod1[15:8];
        loads <= loads + 1;
      end
      if (accb1 == load_accb) begin
        acc_b <= prod1[7:0];
        loads <= loads + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one MUL on dut1; hold is asserted for edges hold_from+1 .. hold_from+hold_len.
  // Returns the edge index (after the start edge) at which done was seen, or -1.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input int hold_from,
                        input int hold_len, input bit spam, output int kd);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    hold  = 1'b0;
    tick();
    start = spam;
    a_in  = ~a;
    b_in  = b ^ 8'h5A;
    hold  = (1 > hold_from && 1 <= hold_from + hold_len);
    kd    = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      hold = ((k + 1) > hold_from && (k + 1) <= hold_from + hold_len);
      #1;
      if (hold) begin
        check("hold_done", 32'(done1), 32'd0);
        check("hold_acca", 32'(acca1), 32'(latch_acca));
      end
      if (done1) begin
        kd = k;
        break;
      end
    end
    hold = 1'b0;
    if (kd < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int         kd;
    logic [7:0] ra, rb;
    logic [15:0] exp;

    // Reset state
    #12;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_prod", 32'(prod1), 32'd0);
    check("rst_c", 32'(c1), 32'd0);
    check("rst_acca", 32'(acca1), 32'(latch_acca));
    check("rst_accb", 32'(accb1), 32'(latch_accb));
    tick();
    rst_n = 1'b1;
    tick();

    // 1: reset mid-CALC aborts with no accumulator write
    a_in = 8'h12; b_in = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t1_busy_calc", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_abort_busy", 32'(busy1), 32'd0);
    check("t1_abort_acca", 32'(acca1), 32'(latch_acca));
    check("t1_abort_accb", 32'(accb1), 32'(latch_accb));
    check("t1_abort_prod", 32'(prod1), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_idle_busy", 32'(busy1), 32'd0);
      check("t1_idle_acca", 32'(acca1), 32'(latch_acca));
    end
    check("t1_no_loads", 32'(loads), 32'd0);

    // 2: FF * FF
    do_mul(8'hFF, 8'hFF, 0, 0, 1'b0, kd);
    check("t2_cycle", 32'(kd + 1), 32'd9);
    check("t2_prod", 32'(prod1), 32'hFE01);
    check("t2_c", 32'(c1), 32'd0);
    check("t2_busy", 32'(busy1), 32'd1);
    check("t2_acca", 32'(acca1), 32'(load_hi_acca));
    check("t2_accb", 32'(accb1), 32'(load_accb));
    tick();
    check("t2_acc_a", 32'(acc_a), 32'hFE);
    check("t2_acc_b", 32'(acc_b), 32'h01);
    check("t2_idle", 32'(busy1), 32'd0);
    check("t2_done_low", 32'(done1), 32'd0);
    check("t2_prod_held", 32'(prod1), 32'hFE01);

    // 3: carry from bit 7, and zero operand
    do_mul(8'h0C, 8'h0B, 0, 0, 1'b0, kd);
    check("t3a_prod", 32'(prod1), 32'h0084);
    check("t3a_c", 32'(c1), 32'd1);
    tick();
    check("t3a_acc_a", 32'(acc_a), 32'h00);
    check("t3a_acc_b", 32'(acc_b), 32'h84);
    do_mul(8'h00, 8'h0B, 0, 0, 1'b0, kd);
    check("t3b_prod", 32'(prod1), 32'h0000);
    check("t3b_c", 32'(c1), 32'd0);
    tick();

    // 4: hold for 3 CALC cycles delays done by 3
    do_mul(8'h80, 8'h02, 2, 3, 1'b0, kd);
    check("t4_cycle", 32'(kd + 1), 32'd12);
    check("t4_prod", 32'(prod1), 32'h0100);
    tick();
    check("t4_acc_a", 32'(acc_a), 32'h01);
    check("t4_acc_b", 32'(acc_b), 32'h00);

    // 5: start held high while busy, then a fresh run
    do_mul(8'h21, 8'h03, 0, 0, 1'b1, kd);
    check("t5_cycle", 32'(kd + 1), 32'd9);
    check("t5_prod", 32'(prod1), 32'h0063);
    tick();
    check("t5_no_requeue", 32'(busy1), 32'd0);
    check("t5_no_done", 32'(done1), 32'd0);
    start = 1'b0;
    tick();
    do_mul(8'h05, 8'h07, 0, 0, 1'b0, kd);
    check("t5b_cycle", 32'(kd + 1), 32'd9);
    check("t5b_prod", 32'(prod1), 32'h0023);
    check("t5b_c", 32'(c1), 32'd0);
    tick();

    // 6: random operands on all step widths
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp = {8'h00, ra} * {8'h00, rb};
      a_in = ra; b_in = rb; start = 1'b1;
      tick();
      start = 1'b0;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      for (int k = 1; k <= 8; k++) begin
        tick();
        check("r_done4", 32'(done4), 32'(k == 2));
        check("r_done2", 32'(done2), 32'(k == 4));
        check("r_done1", 32'(done1), 32'(k == 8));
        if (k == 2) check("r_prod4", 32'(prod4), 32'(exp));
        if (k == 4) check("r_prod2", 32'(prod2), 32'(exp));
        if (k == 8) check("r_prod1", 32'(prod1), 32'(exp));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
